// File: rtl/oled_frame_sequencer.sv
// SSD1306 128x64 refresh sequencer: power-up wait, init stream,
// then per-frame addressing preamble plus 1024 display bytes.
module oled_frame_sequencer #(
  parameter logic [23:0] PWR_WAIT = 24'd1_000_000,
  parameter int          RD_LAT   = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       refresh_en,
  output logic [9:0] byte_counter,
  input  logic [7:0] pixel_data,
  output logic       tx_valid,
  output logic [7:0] tx_data,
  output logic       tx_dc,
  input  logic       tx_ready,
  output logic       frame_done,
  output logic       busy
);

  localparam logic [2:0] S_PWR   = 3'd0;
  localparam logic [2:0] S_INIT  = 3'd1;
  localparam logic [2:0] S_ADDR  = 3'd2;
  localparam logic [2:0] S_IDLE  = 3'd3;
  localparam logic [2:0] S_FETCH = 3'd4;
  localparam logic [2:0] S_SEND  = 3'd5;

  localparam int FW = (RD_LAT < 1) ? 1 : $clog2(RD_LAT + 1);
  localparam logic [FW-1:0] F_LAST = FW'(RD_LAT);
  localparam logic [23:0]   P_LAST = PWR_WAIT - 24'd1;

  logic [2:0]    state;
  logic [23:0]   pcnt;
  logic [4:0]    idx;
  logic [FW-1:0] fcnt;
  logic          acc;

  assign acc  = tx_valid && tx_ready;
  assign busy = (state != S_IDLE);

  function automatic logic [7:0] init_rom(input logic [4:0] i);
    logic [7:0] b;
    case (i)
      5'd0:  b = 8'hAE;
      5'd1:  b = 8'hD5;
      5'd2:  b = 8'h80;
      5'd3:  b = 8'hA8;
      5'd4:  b = 8'h3F;
      5'd5:  b = 8'hD3;
      5'd6:  b = 8'h00;
      5'd7:  b = 8'h40;
      5'd8:  b = 8'h8D;
      5'd9:  b = 8'h14;
      5'd10: b = 8'h20;
      5'd11: b = 8'h00;
      5'd12: b = 8'hA1;
      5'd13: b = 8'hC8;
      5'd14: b = 8'hDA;
      5'd15: b = 8'h12;
      5'd16: b = 8'h81;
      5'd17: b = 8'hCF;
      5'd18: b = 8'hD9;
      5'd19: b = 8'hF1;
      5'd20: b = 8'hDB;
      5'd21: b = 8'h40;
      5'd22: b = 8'hA4;
      5'd23: b = 8'hA6;
      5'd24: b = 8'hAF;
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  // Column 0..127, page 0..7 window for horizontal addressing
  function automatic logic [7:0] addr_rom(input logic [2:0] i);
    logic [7:0] b;
    case (i)
      3'd0: b = 8'h21;
      3'd1: b = 8'h00;
      3'd2: b = 8'h7F;
      3'd3: b = 8'h22;
      3'd4: b = 8'h00;
      3'd5: b = 8'h07;
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_PWR;
      pcnt         <= '0;
      idx          <= '0;
      fcnt         <= '0;
      byte_counter <= '0;
      tx_valid     <= 1'b0;
      tx_data      <= 8'h00;
      tx_dc        <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      unique case (state)
        S_PWR: begin
          if (pcnt == P_LAST) begin
            state    <= S_INIT;
            idx      <= '0;
            tx_valid <= 1'b1;
            tx_data  <= init_rom(5'd0);
            tx_dc    <= 1'b0;
          end else begin
            pcnt <= pcnt + 24'd1;
          end
        end
        S_INIT: begin
          if (acc) begin
            if (idx == 5'd24) begin
              state    <= S_IDLE;
              tx_valid <= 1'b0;
            end else begin
              idx     <= idx + 5'd1;
              tx_data <= init_rom(idx + 5'd1);
            end
          end
        end
        S_IDLE: begin
          if (refresh_en) begin
            state    <= S_ADDR;
            idx      <= '0;
            tx_valid <= 1'b1;
            tx_data  <= 8'h21;
            tx_dc    <= 1'b0;
          end
        end
        S_ADDR: begin
          if (acc) begin
            if (idx == 5'd5) begin
              state        <= S_FETCH;
              fcnt         <= '0;
              byte_counter <= '0;
              tx_valid     <= 1'b0;
            end else begin
              idx     <= idx + 5'd1;
              tx_data <= addr_rom(idx[2:0] + 3'd1);
            end
          end
        end
        S_FETCH: begin
          if (fcnt == F_LAST) begin
            state    <= S_SEND;
            tx_data  <= pixel_data;
            tx_dc    <= 1'b1;
            tx_valid <= 1'b1;
          end else begin
            fcnt <= fcnt + 1'b1;
          end
        end
        S_SEND: begin
          if (acc) begin
            if (byte_counter == 10'd1023) begin
              frame_done   <= 1'b1;
              byte_counter <= '0;
              // Chain straight into the next preamble when refreshing
              if (refresh_en) begin
                state    <= S_ADDR;
                idx      <= '0;
                tx_valid <= 1'b1;
                tx_data  <= 8'h21;
                tx_dc    <= 1'b0;
              end else begin
                state    <= S_IDLE;
                tx_valid <= 1'b0;
              end
            end else begin
              byte_counter <= byte_counter + 10'd1;
              fcnt         <= '0;
              tx_valid     <= 1'b0;
              state        <= S_FETCH;
            end
          end
        end
        default: state <= S_PWR;
      endcase
    end
  end

endmodule
